ramb16_s2_s2: RTL and testbench
===============================

Name: ramb16_s2_s2

Overview:
- Behavioural true-dual-port 16 Kbit block RAM, organised as 8192 words x 2 bits per port.
- Ports A and B are symmetric; each has its own address, data in, data out, enable and write enable.
- Both ports share one clock and one synchronous reset.
- Used as the technology-mapped storage primitive underneath the 8192x2 dual-port memory wrappers.

Parameters:
- INIT_A, 2'b00, power-up value of DOA.
- INIT_B, 2'b00, power-up value of DOB.
- SRVAL_A, 2'b00, value loaded into DOA by reset.
- SRVAL_B, 2'b00, value loaded into DOB by reset.
- WRITE_MODE_A, "WRITE_FIRST", port A output on a write cycle: WRITE_FIRST, READ_FIRST or NO_CHANGE.
- WRITE_MODE_B, "WRITE_FIRST", same choices for port B.

Ports:
- CLK  in  1  clock for both ports; all activity on the rising edge.
- SSR  in  1  synchronous active-high reset of the output registers; the memory array is not affected.
- ADDRA  in  13  port A word address.
- DIA  in  2  port A write data.
- DOA  out  2  port A registered read data.
- ENA  in  1  port A enable.
- WEA  in  1  port A write enable; only effective when ENA=1.
- ADDRB  in  13  port B word address.
- DIB  in  2  port B write data.
- DOB  out  2  port B registered read data.
- ENB  in  1  port B enable.
- WEB  in  1  port B write enable; only effective when ENB=1.

Behaviour:
- Array: 8192 x 2 bits, all zero at time 0. The array is never cleared by SSR.
- DOA = INIT_A and DOB = INIT_B at time 0.
- Ports are independent and fully synchronous. The per-port rules below are written for port A; port B is identical.
- ENA=0: no read, no write, DOA holds its value. SSR is ignored for this port.
- ENA=1, WEA=1: mem[ADDRA] <= DIA at the edge.
- ENA=1, WEA=0: DOA <= mem[ADDRA] at the edge. Read latency is 1 cycle; the data is valid after the edge where the address was sampled.
- ENA=1, WEA=1, DOA update depends on WRITE_MODE_A:
  - WRITE_FIRST: DOA <= DIA.
  - READ_FIRST: DOA <= old mem[ADDRA].
  - NO_CHANGE: DOA holds.
- ENA=1, SSR=1: DOA <= SRVAL_A, overriding the read/write-mode output. A write requested in the same cycle (WEA=1) is still performed on the array.
- Addresses are 13-bit; all 8192 locations are valid. There is no out-of-range case.
- Same-cycle collisions on the same address:
  - Both ports write: port B's data is stored.
  - One port writes, the other reads: the reading port returns the old contents (pre-edge value). The writing port's output follows its own WRITE_MODE.
  - Both ports read: both return the same stored value.
- Different addresses never interact.
- SSR asserted mid-sequence affects only the outputs of enabled ports. Previously written data remains readable after SSR deasserts.

Test Plan:
- Write/read A: ENA=1, WEA=1, ADDRA=0x0005, DIA=2'b10; next cycle WEA=0, same address -> DOA=2'b10 one edge later. Under WRITE_FIRST, DOA is already 2'b10 after the write edge.
- Cross-port and boundary: port A writes 2'b11 to 0x1FFF and 2'b01 to 0x0000; port B then reads 0x1FFF and 0x0000 -> DOB=2'b11 then 2'b01. Neighbouring address 0x1FFE reads 2'b00.
- Enable gating: ENA=0 with WEA=1, ADDRA=0x0010, DIA=2'b11 -> mem[0x0010] stays 00 and DOA is unchanged. With ENB=0 and SSR=1 -> DOB holds its prior value.
- Reset: DOA=2'b11, then SSR=1 with ENA=1, WEA=1, ADDRA=0x0020, DIA=2'b01 -> DOA=SRVAL_A (00). A later read of 0x0020 returns 2'b01.
- Collision: both ports write 0x0100 in the same cycle (A=2'b01, B=2'b10) -> a later read gives 2'b10. A writes 2'b11 to 0x0100 while B reads 0x0100 -> DOB=2'b10 (old), and the next B read gives 2'b11.
- Write modes: mem[0x0040]=2'b01, then write 2'b10 there -> DOA becomes 2'b10 (WRITE_FIRST), 2'b01 (READ_FIRST), or holds its previous value (NO_CHANGE).

Source files
------------

// File: rtl/ramb16_s2_s2.sv
// ramb16_s2_s2: true-dual-port 8192x2 block RAM with registered outputs and per-port write modes
// Ports: CLK shared clock; SSR sync active-high output reset (array untouched, only enabled ports)
//        ADDRx/DIx/DOx/ENx/WEx per port x in {A,B}: 13-bit address, 2-bit write data,
//        2-bit registered read data, port enable, write enable (gated by ENx)
module ramb16_s2_s2 #(
    parameter logic [1:0] INIT_A       = 2'b00,
    parameter logic [1:0] INIT_B       = 2'b00,
    parameter logic [1:0] SRVAL_A      = 2'b00,
    parameter logic [1:0] SRVAL_B      = 2'b00,
    parameter string      WRITE_MODE_A = "WRITE_FIRST",
    parameter string      WRITE_MODE_B = "WRITE_FIRST"
) (
    input  logic        CLK,
    input  logic        SSR,
    input  logic [12:0] ADDRA,
    input  logic [1:0]  DIA,
    output logic [1:0]  DOA,
    input  logic        ENA,
    input  logic        WEA,
    input  logic [12:0] ADDRB,
    input  logic [1:0]  DIB,
    output logic [1:0]  DOB,
    input  logic        ENB,
    input  logic        WEB
);
    localparam bit a_rf = WRITE_MODE_A == "READ_FIRST";
    localparam bit a_nc = WRITE_MODE_A == "NO_CHANGE";
    localparam bit b_rf = WRITE_MODE_B == "READ_FIRST";
    localparam bit b_nc = WRITE_MODE_B == "NO_CHANGE";
    logic [1:0] mem [8192] = '{default: 2'b00};
    logic [1:0] do_a = INIT_A;
    logic [1:0] do_b = INIT_B;
    assign DOA = do_a;
    assign DOB = do_b;
    // port B is written last so it wins a same-address write collision
    always_ff @(posedge CLK) begin
        if (ENA && WEA) mem[ADDRA] <= DIA;
        if (ENB && WEB) mem[ADDRB] <= DIB;
    end
    // reads see the pre-edge array contents, giving old data on read/write collisions
    always_ff @(posedge CLK) begin
        if (ENA) do_a <= SSR ? SRVAL_A : (!WEA || a_rf) ? mem[ADDRA] : a_nc ? do_a : DIA;
    end
    always_ff @(posedge CLK) begin
        if (ENB) do_b <= SSR ? SRVAL_B : (!WEB || b_rf) ? mem[ADDRB] : b_nc ? do_b : DIB;
    end
endmodule

// File: tb/tb_ramb16_s2_s2.sv
// tb_ramb16_s2_s2: randomized and directed checks of two ramb16_s2_s2 instances against a behavioural model
module tb_ramb16_s2_s2;
    typedef struct {
        logic        ea, wa;
        logic [12:0] aa;
        logic [1:0]  da;
        logic        eb, wb;
        logic [12:0] ab;
        logic [1:0]  db;
        logic        s;
    } stim_t;
    logic        clk = 1'b0;
    logic        ssr, ena, wea, enb, web;
    logic [12:0] addra, addrb;
    logic [1:0]  dia, dib, doa, dob, doa2, dob2;
    logic [1:0]  ref_mem [8192];
    logic [1:0]  xa, xb, xa2, xb2;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    ramb16_s2_s2 dut (
        .CLK(clk), .SSR(ssr),
        .ADDRA(addra), .DIA(dia), .DOA(doa), .ENA(ena), .WEA(wea),
        .ADDRB(addrb), .DIB(dib), .DOB(dob), .ENB(enb), .WEB(web)
    );
    ramb16_s2_s2 #(
        .INIT_A(2'b01), .INIT_B(2'b10), .SRVAL_A(2'b10), .SRVAL_B(2'b01),
        .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE")
    ) dut2 (
        .CLK(clk), .SSR(ssr),
        .ADDRA(addra), .DIA(dia), .DOA(doa2), .ENA(ena), .WEA(wea),
        .ADDRB(addrb), .DIB(dib), .DOB(dob2), .ENB(enb), .WEB(web)
    );
    // mode: 0 write-first, 1 read-first, 2 no-change
    function automatic logic [1:0] port_next(logic [1:0] cur, int mode, logic [1:0] sr,
                                             logic en, logic we, logic s, logic [12:0] a, logic [1:0] d);
        if (!en) return cur;
        if (s) return sr;
        if (!we) return ref_mem[a];
        return mode == 0 ? d : mode == 1 ? ref_mem[a] : cur;
    endfunction
    function automatic stim_t mk(logic ea, logic wa, logic [12:0] aa, logic [1:0] da,
                                 logic eb, logic wb, logic [12:0] ab, logic [1:0] db, logic s);
        stim_t t;
        t.ea = ea; t.wa = wa; t.aa = aa; t.da = da;
        t.eb = eb; t.wb = wb; t.ab = ab; t.db = db; t.s = s;
        return t;
    endfunction
    task automatic cyc(input stim_t t);
        ena = t.ea; wea = t.wa; addra = t.aa; dia = t.da;
        enb = t.eb; web = t.wb; addrb = t.ab; dib = t.db; ssr = t.s;
        xa  = port_next(xa,  0, 2'b00, t.ea, t.wa, t.s, t.aa, t.da);
        xb  = port_next(xb,  0, 2'b00, t.eb, t.wb, t.s, t.ab, t.db);
        xa2 = port_next(xa2, 1, 2'b10, t.ea, t.wa, t.s, t.aa, t.da);
        xb2 = port_next(xb2, 2, 2'b01, t.eb, t.wb, t.s, t.ab, t.db);
        if (t.ea && t.wa) ref_mem[t.aa] = t.da;
        if (t.eb && t.wb) ref_mem[t.ab] = t.db;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        n_cmp++;
        if ({doa, dob, doa2, dob2} !== 8'b00_00_01_10) begin
            n_bad++;
            $display("FAIL reset_init: got %b want %b", {doa, dob, doa2, dob2}, 8'b00_00_01_10);
        end
        cyc(mk(1, 0, 13'h0, 2'b00, 1, 0, 13'h0, 2'b00, 1));
        n_cmp++;
        if ({doa, dob, doa2, dob2} !== 8'b00_00_10_01) begin
            n_bad++;
            $display("FAIL reset_srval: got %b want %b", {doa, dob, doa2, dob2}, 8'b00_00_10_01);
        end
    endtask
    task automatic test_write_read();
        stim_t q[$];
        q.push_back(mk(1, 1, 13'h0005, 2'b10, 0, 0, 13'h0, 2'b00, 0));
        q.push_back(mk(1, 0, 13'h0005, 2'b00, 0, 0, 13'h0, 2'b00, 0));
        foreach (q[i]) begin
            cyc(q[i]);
            n_cmp++;
            if ({doa, dob, doa2, dob2} !== {xa, xb, xa2, xb2} || doa !== 2'b10) begin
                n_bad++;
                $display("FAIL write_read step %0d: got %b want %b", i, {doa, dob, doa2, dob2}, {xa, xb, xa2, xb2});
            end
        end
    endtask
    task automatic test_cross_port();
        stim_t q[$];
        logic [1:0] want[4] = '{2'b00, 2'b11, 2'b01, 2'b00};
        q.push_back(mk(1, 1, 13'h1FFF, 2'b11, 0, 0, 13'h0, 2'b00, 0));
        q.push_back(mk(1, 1, 13'h0000, 2'b01, 1, 0, 13'h1FFF, 2'b00, 0));
        q.push_back(mk(0, 0, 13'h0000, 2'b00, 1, 0, 13'h0000, 2'b00, 0));
        q.push_back(mk(0, 0, 13'h0000, 2'b00, 1, 0, 13'h1FFE, 2'b00, 0));
        foreach (q[i]) begin
            cyc(q[i]);
            n_cmp++;
            if ({doa, dob, doa2, dob2} !== {xa, xb, xa2, xb2} || (i > 0 && dob !== want[i])) begin
                n_bad++;
                $display("FAIL cross_port step %0d: got %b want %b", i, {doa, dob, doa2, dob2}, {xa, xb, xa2, xb2});
            end
        end
    endtask
    task automatic test_enable();
        stim_t q[$];
        q.push_back(mk(0, 1, 13'h0010, 2'b11, 0, 1, 13'h0011, 2'b11, 0));
        q.push_back(mk(0, 0, 13'h0000, 2'b00, 0, 0, 13'h0000, 2'b00, 1));
        q.push_back(mk(1, 0, 13'h0010, 2'b00, 1, 0, 13'h0011, 2'b00, 0));
        foreach (q[i]) begin
            cyc(q[i]);
            n_cmp++;
            if ({doa, dob, doa2, dob2} !== {xa, xb, xa2, xb2}) begin
                n_bad++;
                $display("FAIL enable step %0d: got %b want %b", i, {doa, dob, doa2, dob2}, {xa, xb, xa2, xb2});
            end
        end
    endtask
    task automatic test_ssr_write();
        stim_t q[$];
        q.push_back(mk(1, 1, 13'h0021, 2'b11, 0, 0, 13'h0, 2'b00, 0));
        q.push_back(mk(1, 0, 13'h0021, 2'b00, 0, 0, 13'h0, 2'b00, 0));
        q.push_back(mk(1, 1, 13'h0020, 2'b01, 1, 0, 13'h0021, 2'b00, 1));
        q.push_back(mk(1, 0, 13'h0020, 2'b00, 1, 0, 13'h0020, 2'b00, 0));
        foreach (q[i]) begin
            cyc(q[i]);
            n_cmp++;
            if ({doa, dob, doa2, dob2} !== {xa, xb, xa2, xb2}) begin
                n_bad++;
                $display("FAIL ssr_write step %0d: got %b want %b", i, {doa, dob, doa2, dob2}, {xa, xb, xa2, xb2});
            end
        end
    endtask
    task automatic test_collision();
        stim_t q[$];
        q.push_back(mk(1, 1, 13'h0100, 2'b01, 1, 1, 13'h0100, 2'b10, 0));
        q.push_back(mk(1, 0, 13'h0100, 2'b00, 1, 0, 13'h0100, 2'b00, 0));
        q.push_back(mk(1, 1, 13'h0100, 2'b11, 1, 0, 13'h0100, 2'b00, 0));
        q.push_back(mk(0, 0, 13'h0100, 2'b00, 1, 0, 13'h0100, 2'b00, 0));
        foreach (q[i]) begin
            cyc(q[i]);
            n_cmp++;
            if ({doa, dob, doa2, dob2} !== {xa, xb, xa2, xb2} || dob !== (i == 3 ? 2'b11 : 2'b10)) begin
                n_bad++;
                $display("FAIL collision step %0d: got %b want %b", i, {doa, dob, doa2, dob2}, {xa, xb, xa2, xb2});
            end
        end
    endtask
    task automatic test_write_modes();
        stim_t q[$];
        q.push_back(mk(1, 1, 13'h0040, 2'b01, 1, 1, 13'h0041, 2'b11, 0));
        q.push_back(mk(1, 0, 13'h0042, 2'b00, 1, 0, 13'h0042, 2'b00, 0));
        q.push_back(mk(1, 1, 13'h0040, 2'b10, 1, 1, 13'h0041, 2'b01, 0));
        foreach (q[i]) begin
            cyc(q[i]);
            n_cmp++;
            if ({doa, dob, doa2, dob2} !== {xa, xb, xa2, xb2}) begin
                n_bad++;
                $display("FAIL write_modes step %0d: got %b want %b", i, {doa, dob, doa2, dob2}, {xa, xb, xa2, xb2});
            end
        end
        n_cmp++;
        if ({doa, doa2, dob2} !== 6'b10_01_00) begin
            n_bad++;
            $display("FAIL write_modes_final: got %b want %b", {doa, doa2, dob2}, 6'b10_01_00);
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            cyc(mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 13'($urandom_range(0, 7)), 2'($urandom),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 13'($urandom_range(0, 7)), 2'($urandom),
                   $urandom_range(0, 9) == 0));
            n_cmp++;
            if ({doa, dob, doa2, dob2} !== {xa, xb, xa2, xb2}) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %b want %b", i, {doa, dob, doa2, dob2}, {xa, xb, xa2, xb2});
            end
        end
    endtask
    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 2'b00;
        xa = 2'b00; xb = 2'b00; xa2 = 2'b01; xb2 = 2'b10;
        ssr = 0; ena = 0; wea = 0; enb = 0; web = 0;
        addra = '0; addrb = '0; dia = '0; dib = '0;
        #1;
        test_reset();
        test_write_read();
        test_cross_port();
        test_enable();
        test_ssr_write();
        test_collision();
        test_write_modes();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
